embedding_seq_lookup: RTL
=========================

Name: embedding_seq_lookup

Overview:
- Parametrised, handshaked successor to the single-bit embedding stage.
- Holds a writable EM_IN x EM_DIM fixed-point embedding table.
- Accepts a packet of N_TOK token indices and emits one EM_DIM-wide embedding vector per token, serially, to the LSTM input stage.
- Adds over the previous block: arbitrary vocabulary size, multi-token packets, valid/ready back-pressure, runtime table load, out-of-range detection.

Parameters:
- QN, 6, integer bits of Q-format word.
- QM, 11, fractional bits of Q-format word.
- EM_IN, 16, vocabulary size (table rows); need not be a power of two; minimum 2.
- EM_DIM, 8, embedding elements per row.
- N_TOK, 4, token indices per input packet; minimum 1.
- BITWIDTH, QN+QM+1, derived element width.
- IDX_W, log2(EM_IN-1)+1, derived index width (ceil log2 EM_IN).
- LAYER_BITWIDTH, BITWIDTH*EM_DIM, derived row width.

Ports:
- clock, input, 1, single clock, all logic on rising edge.
- reset, input, 1, asynchronous, active-low reset.
- wr_en, input, 1, table write strobe.
- wr_addr, input, IDX_W, table row to write.
- wr_data, input, LAYER_BITWIDTH, row data; element 0 in LSBs.
- in_valid, input, 1, index packet valid.
- in_ready, output, 1, block can accept a packet.
- in_idx, input, N_TOK*IDX_W, packed indices; token 0 in LSBs.
- out_valid, output, 1, outputVec valid.
- out_ready, input, 1, downstream accepts beat.
- outputVec, output, LAYER_BITWIDTH, embedding row for the current token.
- out_last, output, 1, beat carries token N_TOK-1.
- out_oob, output, 1, current token index >= EM_IN; outputVec forced to zero.

Behaviour:
- Reset (reset=0, async assert, sync release):
  - FSM to IDLE, tok_cnt=0.
  - in_ready=0 while reset is held; 1 in the first cycle after release.
  - out_valid, out_last, out_oob = 0; outputVec = 0.
  - Table contents are NOT reset.
  - Reset mid-packet aborts the packet with no further beats.
- FSM states: IDLE, READ, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_idx, tok_cnt=0, go to READ.
- READ:
  - in_ready=0.
  - Registered table read of index[tok_cnt]; go to OUT next cycle.
- OUT:
  - out_valid=1; outputVec, out_oob, out_last stay stable until accepted.
  - On out_ready:
    - If tok_cnt==N_TOK-1: go to IDLE.
    - Else: tok_cnt++, go to READ.
  - Without out_ready: hold all outputs indefinitely.
- Timing:
  - Latency: packet accepted at edge T gives first out_valid=1 after edge T+2.
  - Max throughput: one token per 2 cycles.
  - Next packet can be accepted in the cycle after the last beat is taken.
  - out_valid drops in the cycle after acceptance of the last beat.
- out_last = (tok_cnt==N_TOK-1) while out_valid=1; 0 otherwise. N_TOK=1 gives out_last=1 on every beat.
- Out of range: index >= EM_IN gives outputVec=0 and out_oob=1. No table access; FSM proceeds normally.
- Table write:
  - wr_en is honoured in every state, including during reset release.
  - Write with wr_addr >= EM_IN is dropped.
  - Write and READ to the same row in the same cycle: the read returns the old data. The new data is visible from the next READ.
- Indices are unsigned. Data is passed through unmodified; no arithmetic on table values.

Test Plan:
- Table load and single packet:
  - Load row r with value {EM_DIM elements = r*16+e}, EM_IN=16, N_TOK=4.
  - Send packet {3,0,15,7} with out_ready=1.
  - Required: 4 beats carry rows 3,0,15,7.
  - Required: first out_valid 2 cycles after acceptance; beats 2 cycles apart; out_last only on the row-7 beat; in_ready=0 throughout.
- Back-pressure:
  - Same packet with out_ready=0 for 5 cycles on beat 1.
  - Required: outputVec and out_last held stable; no beat lost or duplicated; order preserved.
- Out of range:
  - EM_IN=10, packet {9,10,12,1}.
  - Required: beats 2 and 3 give outputVec=0 and out_oob=1; beats 1 and 4 give correct rows with out_oob=0.
- Write collision:
  - Row 5 holds A; packet {5,5}.
  - Write B to row 5 in the first READ cycle.
  - Required: beat 1 returns A, beat 2 returns B.
- Reset mid-packet:
  - Drop reset during beat 2 of 4.
  - Required: outputs 0 asynchronously.
  - Required: in_ready=1 one cycle after release.
  - Required: the table still holds the values written before reset.
- Back-to-back packets:
  - Hold in_valid=1 with two packets, N_TOK=1.
  - Required: each accepted packet yields exactly one beat with out_last=1.
  - Required: second acceptance occurs the cycle after the first beat handshake.

Source files
------------

// File: rtl/embedding_seq_lookup.sv
`default_nettype none
// ============================================================================
// Module      : embedding_seq_lookup
// Description : Writable EM_IN x EM_DIM embedding table. Accepts a packet of
//               N_TOK token indices and streams one embedding row per token
//               over a valid/ready interface. Out-of-range tokens produce a
//               zero row flagged with out_oob.
// Revision    : 1.0 - initial release
// ============================================================================
module embedding_seq_lookup #(
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int EM_IN          = 16,
    parameter int EM_DIM         = 8,
    parameter int N_TOK          = 4,
    parameter int BITWIDTH       = QN + QM + 1,
    parameter int IDX_W          = $clog2(EM_IN),
    parameter int LAYER_BITWIDTH = BITWIDTH * EM_DIM
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_addr,
    input  logic [LAYER_BITWIDTH-1:0] wr_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_TOK*IDX_W-1:0]    in_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LAYER_BITWIDTH-1:0] outputVec,
    output logic                      out_last,
    output logic                      out_oob
);

    // Token counter width; a single-token packet still needs one bit.
    localparam int             CW       = (N_TOK > 1) ? $clog2(N_TOK) : 1;
    localparam logic [CW-1:0]  LAST_TOK = CW'(N_TOK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               tok_cnt_q, tok_cnt_d;
    logic [N_TOK*IDX_W-1:0]      idx_q, idx_d;
    logic [LAYER_BITWIDTH-1:0]   vec_q;
    logic                        oob_q;
    logic                        alive_q;

    // Table storage; deliberately has no reset so contents survive reset.
    logic [LAYER_BITWIDTH-1:0]   table_q [EM_IN];

    logic [IDX_W-1:0]            cur_idx;
    logic [31:0]                 cur_idx_ext;
    logic [31:0]                 wr_addr_ext;
    logic                        cur_in_range;
    logic                        wr_in_range;

    // Index of the token currently being served, and range checks done at
    // 32 bits so a power-of-two EM_IN does not yield a constant comparison.
    assign cur_idx      = IDX_W'(idx_q >> (tok_cnt_q * IDX_W));
    assign cur_idx_ext  = 32'(cur_idx);
    assign wr_addr_ext  = 32'(wr_addr);
    assign cur_in_range = (cur_idx_ext < 32'(EM_IN));
    assign wr_in_range  = (wr_addr_ext < 32'(EM_IN));

    // Table write port; active in every state and regardless of reset.
    always_ff @(posedge clock) begin
        if (wr_en && wr_in_range) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // State, token counter and latched packet registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tok_cnt_q <= '0;
            idx_q     <= '0;
            alive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tok_cnt_q <= tok_cnt_d;
            idx_q     <= idx_d;
            alive_q   <= 1'b1;
        end
    end

    // Next-state logic: IDLE -> READ -> OUT -> (READ | IDLE).
    always_comb begin
        state_d   = state_q;
        tok_cnt_d = tok_cnt_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    idx_d     = in_idx;
                    tok_cnt_d = '0;
                    state_d   = READ;
                end
            end
            READ: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (tok_cnt_q == LAST_TOK) begin
                        state_d = IDLE;
                    end else begin
                        tok_cnt_d = tok_cnt_q + 1'b1;
                        state_d   = READ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered table read; a write to the same row in this cycle is not
    // seen until the next read because the table updates on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vec_q <= '0;
            oob_q <= 1'b0;
        end else if (state_q == READ) begin
            vec_q <= cur_in_range ? table_q[cur_idx] : '0;
            oob_q <= !cur_in_range;
        end
    end

    assign in_ready  = (state_q == IDLE) && alive_q;
    assign out_valid = (state_q == OUT);
    assign out_last  = out_valid && (tok_cnt_q == LAST_TOK);
    assign out_oob   = out_valid && oob_q;
    assign outputVec = vec_q;

endmodule
`default_nettype wire
